// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between instruction fetch and load/store.
// Latency: read = READ_LAT+2 cycles from request to pulse, store = 2 cycles.
// Backpressure: requests are held by the requesters; stall_if/stall_d freeze them until their pulse.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   if_req/if_addr       fetch request; if_data/if_valid return the instruction
//   d_re/d_we/d_addr/d_wdata  load/store request; d_rdata/d_done return the result
//   stall_if/stall_d     requester outstanding and not completing this cycle
//   mem_*                memory port; mem_rdata is valid READ_LAT cycles after the mem_re cycle
module mem_port_arbiter #(
  parameter int ABUS      = 32,
  parameter int DBUS      = 32,
  parameter int READ_LAT  = 1,
  parameter int FETCH_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [ABUS-1:0] if_addr,
  output logic [DBUS-1:0] if_data,
  output logic            if_valid,
  input  logic            d_re,
  input  logic            d_we,
  input  logic [ABUS-1:0] d_addr,
  input  logic [DBUS-1:0] d_wdata,
  output logic [DBUS-1:0] d_rdata,
  output logic            d_done,
  output logic            stall_if,
  output logic            stall_d,
  output logic [ABUS-1:0] mem_addr,
  output logic [DBUS-1:0] mem_wdata,
  output logic            mem_re,
  output logic            mem_we,
  input  logic [DBUS-1:0] mem_rdata
);

  localparam int CW = (READ_LAT  < 2) ? 1 : $clog2(READ_LAT + 1);
  localparam int SW = (FETCH_MAX < 2) ? 1 : $clog2(FETCH_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic            gnt_if_q;   // 1: transaction in flight belongs to fetch
  logic [CW-1:0]   lat_q;
  logic [SW-1:0]   starve_cnt;

  logic d_req;
  logic any_req;
  logic pick_if;
  logic starved;

  assign d_req   = d_re | d_we;
  assign any_req = if_req | d_req;
  assign starved = (starve_cnt == SW'(FETCH_MAX));
  // Data normally wins; fetch overrides once it has lost FETCH_MAX grants in a row.
  assign pick_if = if_req & (~d_req | starved);

  always_comb begin
    state_d  = state_q;
    if_valid = 1'b0;
    d_done   = 1'b0;
    case (state_q)
      IDLE:  if (any_req) state_d = ISSUE;
      ISSUE: state_d = mem_we ? RESP : WAIT;
      WAIT:  if (lat_q == CW'(1)) state_d = RESP;
      RESP: begin
        state_d  = IDLE;
        if_valid = gnt_if_q;
        d_done   = ~gnt_if_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_if = if_req & ~if_valid;
  assign stall_d  = d_req & ~d_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_if_q  <= 1'b0;
      lat_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      if_data   <= '0;
      d_rdata   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_if_q <= pick_if;
            if (pick_if) begin
              mem_addr <= if_addr;
              mem_re   <= 1'b1;
            end else begin
              // A simultaneous load and store is carried out as the store alone.
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_we    <= d_we;
              mem_re    <= ~d_we;
            end
          end
        end
        ISSUE: begin
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          lat_q  <= CW'(READ_LAT);
        end
        WAIT: begin
          lat_q <= lat_q - CW'(1);
          if (lat_q == CW'(1)) begin
            if (gnt_if_q) if_data <= mem_rdata;
            else          d_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Counts data grants taken while fetch was waiting; any gap in if_req forgives the debt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!if_req) begin
      starve_cnt <= '0;
    end else if (state_q == IDLE && any_req) begin
      if (pick_if)       starve_cnt <= '0;
      else if (!starved) starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int RL = 1;
  localparam int FM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_valid;
  logic        d_re, d_we;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_done, stall_if, stall_d;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ABUS(32), .DBUS(32), .READ_LAT(RL), .FETCH_MAX(FM)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_valid(if_valid),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .stall_if(stall_if), .stall_d(stall_d),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Behavioural memory: word-indexed by the low address bits, read data appears
  // RL cycles after the mem_re cycle; other cycles carry a junk pattern.
  logic [31:0] mem [0:63];
  logic [31:0] rd_pipe [0:RL-1];
  int          we_cnt;
  assign mem_rdata = rd_pipe[RL-1];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[2]  <= 32'h0000_003F;
      mem[4]  <= 32'h2100_0013;
      mem[8]  <= 32'h0;
      mem[16] <= 32'h0;
      for (int i = 0; i < RL; i++) rd_pipe[i] <= 32'hDEAD_BEEF;
    end else begin
      if (mem_we) begin
        mem[mem_addr[5:0]] <= mem_wdata;
        we_cnt <= we_cnt + 1;
      end
      rd_pipe[0] <= mem_re ? mem[mem_addr[5:0]] : 32'hDEAD_BEEF;
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Steps cycles until the selected pulse is seen; n is the cycle it arrived in
  // counting the caller's request cycle as 0.
  task automatic wait_pulse(input bit fetch, output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      next_cycle();
      @(negedge clk);
      n++;
      if (fetch ? if_valid : d_done) return;
    end
    chk("pulse_timeout", 32'(n), 32'(0));
  endtask

  int n, c, dg;
  bit dd_prev, seen_fetch, got_if;
  int ifv_cnt;

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_re = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; we_cnt = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_re",  32'(mem_re), 0);
    chk("rst_mem_we",  32'(mem_we), 0);
    chk("rst_addr",    mem_addr, 0);
    chk("rst_valid",   32'({if_valid, d_done}), 0);
    chk("rst_stall",   32'({stall_if, stall_d}), 0);
    rst = 1'b1;

    // Single fetch
    next_cycle(); if_req = 1'b1; if_addr = 32'h4;
    @(negedge clk); chk("f_c0_stall", 32'(stall_if), 1); chk("f_c0_re", 32'(mem_re), 0);
    next_cycle(); @(negedge clk);
    chk("f_c1_re", 32'(mem_re), 1); chk("f_c1_addr", mem_addr, 32'h4);
    chk("f_c1_stall", 32'(stall_if), 1);
    next_cycle(); @(negedge clk);
    chk("f_c2_re", 32'(mem_re), 0); chk("f_c2_valid", 32'(if_valid), 0);
    chk("f_c2_stall", 32'(stall_if), 1);
    next_cycle(); @(negedge clk);
    chk("f_c3_valid", 32'(if_valid), 1); chk("f_c3_data", if_data, 32'h2100_0013);
    chk("f_c3_stall", 32'(stall_if), 0);
    next_cycle(); if_req = 1'b0;
    @(negedge clk); chk("f_after_valid", 32'(if_valid), 0);
    chk("f_hold_data", if_data, 32'h2100_0013);

    // Store then load
    next_cycle(); d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h9; we_cnt = 0;
    @(negedge clk); chk("st_stall", 32'(stall_d), 1);
    next_cycle(); @(negedge clk);
    chk("st_we", 32'(mem_we), 1); chk("st_re", 32'(mem_re), 0);
    chk("st_addr", mem_addr, 32'h8); chk("st_wdata", mem_wdata, 32'h9);
    next_cycle(); @(negedge clk);
    chk("st_done_c2", 32'(d_done), 1);
    next_cycle(); d_we = 1'b0; d_re = 1'b1; d_addr = 32'h2;
    @(negedge clk);
    chk("st_we_once", 32'(we_cnt), 1); chk("st_mem", mem[8], 32'h9);
    wait_pulse(1'b0, n);
    chk("ld_lat", 32'(n), 32'(RL + 2)); chk("ld_data", d_rdata, 32'h3F);
    next_cycle(); d_addr = 32'h8;
    @(negedge clk);
    wait_pulse(1'b0, n);
    chk("ld_back_data", d_rdata, 32'h9);
    next_cycle(); d_re = 1'b0;

    // Conflict: load and store together act as a store
    next_cycle(); d_re = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h55;
    @(negedge clk);
    next_cycle(); @(negedge clk);
    chk("cf_we", 32'(mem_we), 1); chk("cf_re", 32'(mem_re), 0);
    next_cycle(); @(negedge clk);
    chk("cf_done_c2", 32'(d_done), 1);
    next_cycle(); d_re = 1'b0; d_we = 1'b0;
    @(negedge clk); chk("cf_mem", mem[16], 32'h55);

    // Priority: data first, then fetch
    next_cycle(); if_req = 1'b1; if_addr = 32'h4; d_re = 1'b1; d_addr = 32'h2;
    @(negedge clk);
    next_cycle(); @(negedge clk);
    chk("pr_first_addr", mem_addr, 32'h2);
    dd_prev = 1'b0; got_if = 1'b0;
    for (c = 2; c < 60; c++) begin
      next_cycle();
      if (dd_prev) d_re = 1'b0;
      @(negedge clk);
      dd_prev = d_done;
      if (d_done) chk("pr_d_done_cyc", 32'(c), 32'(RL + 2));
      if (if_valid) begin
        got_if = 1'b1;
        break;
      end
    end
    chk("pr_if_valid_cyc", 32'(c), 32'(2 * RL + 5));
    chk("pr_if_seen", 32'(got_if), 1);
    next_cycle(); if_req = 1'b0;

    // Starvation bound
    next_cycle(); if_req = 1'b1; if_addr = 32'h4; d_re = 1'b1; d_addr = 32'h2;
    dg = 0; seen_fetch = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_re && mem_addr == 32'h2) dg++;
      if (mem_re && mem_addr == 32'h4) begin
        seen_fetch = 1'b1;
        break;
      end
      next_cycle();
    end
    chk("sv_fetch_seen", 32'(seen_fetch), 1);
    chk("sv_data_grants", 32'(dg), 32'(FM));
    chk("sv_cnt_clear", 32'(u_dut.starve_cnt), 0);
    next_cycle(); d_re = 1'b0;
    @(negedge clk);
    if (!if_valid) wait_pulse(1'b1, n);
    chk("sv_if_data", if_data, 32'h2100_0013);
    next_cycle(); if_req = 1'b0;
    @(negedge clk);

    // Reset in the middle of a read
    next_cycle(); if_req = 1'b1; if_addr = 32'h4;
    next_cycle(); next_cycle();
    #2 rst = 1'b0;
    #1;
    chk("rr_mem_re", 32'(mem_re), 0); chk("rr_mem_addr", mem_addr, 0);
    chk("rr_mem_wdata", mem_wdata, 0); chk("rr_if_data", if_data, 0);
    chk("rr_d_rdata", d_rdata, 0); chk("rr_pulses", 32'({if_valid, d_done}), 0);
    chk("rr_stall_if", 32'(stall_if), 1);
    if_req = 1'b0;
    next_cycle(); rst = 1'b1;
    ifv_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if_valid) ifv_cnt++;
      next_cycle();
    end
    chk("rr_no_valid", 32'(ifv_cnt), 0);
    chk("rr_state_idle", 32'(u_dut.state_q), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
